// File: rtl/gaussian_nb_mul_pipe_pkg.sv
// Shared constants and helpers for the gaussian_nb multiplier pipeline.
// Holds the default operand/result widths, product width and saturation bounds.
package gaussian_nb_pkg;

    localparam int DEF_DIN0_WIDTH = 16;
    localparam int DEF_DIN1_WIDTH = 25;
    localparam int DEF_DOUT_WIDTH = 41;
    localparam int DEF_NUM_STAGE  = 4;

    // Bounds are built in a wide word and sliced down to the result width by the user.
    localparam int SAT_W_MAX = 128;

    typedef logic signed [SAT_W_MAX-1:0] sat_word_t;

    typedef struct packed {
        sat_word_t hi;
        sat_word_t lo;
    } sat_bounds_t;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    function automatic sat_bounds_t sat_bounds(input int w);
        sat_bounds_t b;
        b.hi = (sat_word_t'(1) <<< (w - 1)) - sat_word_t'(1);
        b.lo = -(sat_word_t'(1) <<< (w - 1));
        return b;
    endfunction

endpackage

// File: rtl/gaussian_nb_mul_pipe_if.sv
// Operand/result bundle of the gaussian_nb multiplier pipeline.
// The master drives operands and the clock enable; the slave returns the product.
interface gaussian_nb_mul_pipe_if #(
    parameter int DIN0_WIDTH = gaussian_nb_pkg::DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = gaussian_nb_pkg::DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = gaussian_nb_pkg::DEF_DOUT_WIDTH
);

    logic                         ce;
    logic                         in_valid;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         ovf;

    modport master (
        output ce,
        output in_valid,
        output din0,
        output din1,
        input  out_valid,
        input  dout,
        input  ovf
    );

    modport slave (
        input  ce,
        input  in_valid,
        input  din0,
        input  din1,
        output out_valid,
        output dout,
        output ovf
    );

endinterface

// File: rtl/gaussian_nb_mul_pipe_postproc.sv
// Combinational fixed-point post-processing of a full signed product:
// optional round-half-up, arithmetic right shift, then saturate or wrap with an overflow flag.
module gaussian_nb_mul_postproc
    import gaussian_nb_pkg::*;
#(
    parameter int PW         = prod_width(DEF_DIN0_WIDTH, DEF_DIN1_WIDTH),
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 1
) (
    input  logic signed [PW-1:0]         p,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    // One guard bit keeps the rounding add from overflowing.
    localparam int RW      = PW + 1;
    localparam int EW      = (RW > DOUT_WIDTH) ? RW : DOUT_WIDTH;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND_K =
        (ROUND != 0 && SHIFT > 0) ? (RW'(1) <<< RND_POS) : '0;

    localparam sat_bounds_t BND = sat_bounds(DOUT_WIDTH);
    localparam logic signed [DOUT_WIDTH-1:0] DMAX = BND.hi[DOUT_WIDTH-1:0];
    localparam logic signed [DOUT_WIDTH-1:0] DMIN = BND.lo[DOUT_WIDTH-1:0];

    logic signed [RW-1:0] r;
    logic signed [EW-1:0] s;
    logic                 fits;

    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (no latch).
    always_comb begin
        r    = RW'(p) + RND_K;
        s    = EW'(r) >>> SHIFT;
        // S fits when all bits above the result sign bit copy that sign bit.
        fits = (&s[EW-1:DOUT_WIDTH-1]) | ~(|s[EW-1:DOUT_WIDTH-1]);
        dout = s[DOUT_WIDTH-1:0];
        ovf  = 1'b0;
        if (!fits) begin
            ovf = 1'b1;
            if (SAT != 0) begin
                dout = s[EW-1] ? DMIN : DMAX;
            end
        end
    end

endmodule

// File: rtl/gaussian_nb_mul_pipe.sv
// Fully pipelined signed multiplier: operand register, product delay line, registered
// post-processed result, and a valid bit travelling alongside; ce freezes everything.
module gaussian_nb_mul_pipe
    import gaussian_nb_pkg::*;
#(
    parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int NUM_STAGE  = DEF_NUM_STAGE,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    gaussian_nb_mul_pipe_if.slave bus
);

    localparam int PW   = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int NDLY = NUM_STAGE - 2;

    logic signed [DIN0_WIDTH-1:0] a_q;
    logic signed [DIN1_WIDTH-1:0] b_q;
    logic        [NUM_STAGE-1:0]  vld_q;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         p_last;
    logic signed [DOUT_WIDTH-1:0] pp_dout;
    logic                         pp_ovf;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         ovf_q;

    assign prod = PW'(a_q) * PW'(b_q);

    // Stage 1 operands, the valid shift chain and the final result register.
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            vld_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.ce) begin
            a_q    <= bus.din0;
            b_q    <= bus.din1;
            vld_q  <= {vld_q[NUM_STAGE-2:0], bus.in_valid};
            dout_q <= pp_dout;
            ovf_q  <= pp_ovf;
        end
    end

    if (NDLY > 0) begin : g_dly
        logic signed [PW-1:0] dly_q [NDLY];

        // NOTE: this short delay line lives in flops, so clearing it on reset is cheap and keeps idle outputs at 0.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < NDLY; i++) begin
                    dly_q[i] <= '0;
                end
            end else if (bus.ce) begin
                dly_q[0] <= prod;
                for (int i = 1; i < NDLY; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign p_last = dly_q[NDLY-1];
    end else begin : g_nodly
        assign p_last = prod;
    end

    gaussian_nb_mul_postproc #(
        .PW         (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SAT        (SAT)
    ) u_postproc (
        .p    (p_last),
        .dout (pp_dout),
        .ovf  (pp_ovf)
    );

    assign bus.out_valid = vld_q[NUM_STAGE-1];
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

endmodule
